// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: req/ack data bus with byte lanes, load alignment, sign extension and timeout.
// Optional define MEM_ALIGN_CHECK_EN faults misaligned word/half accesses without touching the bus.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_read,
  input  logic [1:0]        mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-3:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;
  typedef enum logic [1:0] {SZ_NONE = 2'b00, SZ_WORD = 2'b01, SZ_BYTE = 2'b10, SZ_HALF = 2'b11} size_e;

  state_e            state_q;
  size_e             size_q;
  logic [1:0]        off_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic              done_q;
  logic              fault_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-3:0] bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [31:0]       bus_wdata_q;

  logic        cmd_d;
  logic        we_d;
  size_e       code_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        misalign_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] load_d;

  // A write command takes priority when Control raises both read and write.
  always_comb begin
    cmd_d   = (mem_read != 2'b00) || (mem_write != 2'b00);
    we_d    = (mem_write != 2'b00);
    code_d  = size_e'(we_d ? mem_write : mem_read);
    be_d    = 4'b0000;
    wdata_d = wdata;
    case (code_d)
      SZ_WORD: be_d = 4'b1111;
      SZ_HALF: begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      default: be_d = 4'b0000;
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    misalign_d = ((code_d == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                 ((code_d == SZ_HALF) && addr[0]);
`else
    misalign_d = 1'b0;
`endif
  end

  always_comb begin
    byte_d = bus_rdata[7:0];
    case (off_q)
      2'd0: byte_d = bus_rdata[7:0];
      2'd1: byte_d = bus_rdata[15:8];
      2'd2: byte_d = bus_rdata[23:16];
      2'd3: byte_d = bus_rdata[31:24];
      default: byte_d = bus_rdata[7:0];
    endcase
    half_d = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_d = {{24{byte_d[7]}}, byte_d};
      SZ_HALF: load_d = {{16{half_d[15]}}, half_d};
      default: load_d = bus_rdata;
    endcase
  end

  // Bus fields are loaded on entry to REQ and zeroed on exit so they are 0 whenever no request is open.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      size_q      <= SZ_NONE;
      off_q       <= 2'b00;
      cnt_q       <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          if (cmd_d) begin
            size_q <= code_d;
            off_q  <= addr[1:0];
            cnt_q  <= '0;
            if (misalign_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q     <= S_REQ;
              bus_req_q   <= 1'b1;
              bus_we_q    <= we_d;
              bus_addr_q  <= addr[ADDR_W-1:2];
              bus_be_q    <= be_d;
              bus_wdata_q <= we_d ? wdata_d : 32'h0;
            end
          end
        end
        S_REQ: begin
          if (bus_ack || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            fault_q     <= !bus_ack;
            rdata_q     <= (bus_ack && !bus_we_q) ? load_d : 32'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall     = ((state_q == S_IDLE) && cmd_d) || (state_q == S_REQ);
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected completions, monitor compares every cycle.
module tb_mem_access_unit;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        mem_read = 2'b00;
  logic [1:0]        mem_write = 2'b00;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic              stall;
  logic              done;
  logic              fault;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-3:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata = '0;
  logic              bus_ack = 1'b0;

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          doneCyc;
    bit          fault;
    bit          isLoad;
    logic [31:0] rdata;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    failures = 0;
  int    gcyc = 0;
  bit    monOn = 1'b0;

  // Expected bus/stall window of the transaction currently in flight
  int          curIssue = -100;
  int          curDone = -100;
  int          curReqFrom = -100;
  int          curReqTo = -101;
  logic        curWe = 1'b0;
  logic [3:0]  curBe = 4'b0;
  logic [31:0] curWd = 32'h0;
  logic [29:0] curAddr = 30'h0;

  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, gcyc);
    end
  endtask

  // Reference model: lane math from byte offsets and sizes, then drive the command and the bus responder.
  task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rdv, input int ackDelay);
    int          op, nBytes, lane, rel, beInt;
    bit          isWrite, mis;
    resp_t       r;
    logic [31:0] mask, v;
    isWrite = (wr != 2'b00);
    op      = isWrite ? int'(wr) : int'(rd);
    nBytes  = (op == 1) ? 4 : (op == 3) ? 2 : 1;
    lane    = (op == 1) ? 0 : (op == 3) ? int'(a[1]) * 2 : int'(a[1:0]);
    mis     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = ((op == 1) && (a[1:0] != 2'b00)) || ((op == 3) && a[0]);
`endif
    mask = (nBytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nBytes)) - 32'h1);
    v    = (rdv >> (8 * lane)) & mask;
    if (nBytes < 4 && v[8 * nBytes - 1]) v = v | ~mask;
    r.isLoad = !isWrite;
    if (mis) begin
      rel = 1; r.fault = 1'b1; r.rdata = 32'h0;
    end else if (ackDelay >= 0 && ackDelay + 1 <= TIMEOUT) begin
      rel = ackDelay + 2; r.fault = 1'b0; r.rdata = v;
    end else begin
      rel = TIMEOUT + 1; r.fault = 1'b1; r.rdata = 32'h0;
    end
    r.doneCyc  = gcyc + rel;
    curIssue   = gcyc;
    curDone    = gcyc + rel;
    curReqFrom = gcyc + 1;
    curReqTo   = mis ? gcyc : gcyc + rel - 1;
    curWe      = isWrite;
    beInt      = ((1 << nBytes) - 1) << lane;
    curBe      = beInt[3:0];
    if (!isWrite)        curWd = 32'h0;
    else if (nBytes == 4) curWd = wd;
    else if (nBytes == 2) curWd = {16'h0, wd[15:0]} * 32'h0001_0001;
    else                  curWd = {24'h0, wd[7:0]} * 32'h0101_0101;
    curAddr = a[31:2];
    sb.push_back(r);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    for (int k = 1; k <= rel; k++) begin
      @(posedge clk); #1;
      bus_ack   = !mis && (ackDelay >= 0) && (k == ackDelay + 1);
      bus_rdata = bus_ack ? rdv : $urandom;
    end
    @(posedge clk); #1;
    mem_read  = 2'b00;
    mem_write = 2'b00;
    bus_ack   = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    bit    expReq;
    resp_t r;
    if (monOn) begin
      expReq = (gcyc >= curReqFrom) && (gcyc <= curReqTo);
      checkOutput("stall", 32'(stall), 32'((gcyc >= curIssue) && (gcyc < curDone)));
      checkOutput("bus_req", 32'(bus_req), 32'(expReq));
      checkOutput("bus_we", 32'(bus_we), expReq ? 32'(curWe) : 32'h0);
      checkOutput("bus_be", 32'(bus_be), expReq ? 32'(curBe) : 32'h0);
      checkOutput("bus_addr", 32'(bus_addr), expReq ? 32'(curAddr) : 32'h0);
      checkOutput("bus_wdata", bus_wdata, expReq ? curWd : 32'h0);
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("done_unexpected", 32'(done), 32'h0);
        end else begin
          r = sb.pop_front();
          checkOutput("done_cycle", 32'(gcyc), 32'(r.doneCyc));
          checkOutput("fault", 32'(fault), 32'(r.fault));
          if (r.isLoad) checkOutput("rdata", rdata, r.rdata);
        end
      end else begin
        checkOutput("fault_without_done", 32'(fault), 32'h0);
        if (sb.size() > 0 && gcyc >= sb[0].doneCyc) begin
          r = sb.pop_front();
          checkOutput("done_missing", 32'(done), 32'h1);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int issue;
    reset = 1'b1;
    @(posedge clk);
    monOn = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_fault", 32'(fault), 32'h0);
    @(posedge clk); #1;

    applyStimulus(2'b00, 2'b01, 32'h10, 32'hDEAD_BEEF, 32'h0, 2);
    applyStimulus(2'b10, 2'b00, 32'h13, 32'h0, 32'h80FF_0000, 1);
    applyStimulus(2'b11, 2'b00, 32'h12, 32'h0, 32'h80FF_0000, 0);
    applyStimulus(2'b00, 2'b10, 32'h21, 32'h0000_00AB, 32'h0, 3);
    applyStimulus(2'b00, 2'b11, 32'h22, 32'h1234_5678, 32'h0, 1);
    applyStimulus(2'b01, 2'b00, 32'h40, 32'h0, 32'hCAFE_F00D, -1);
    applyStimulus(2'b01, 2'b00, 32'h44, 32'h0, 32'h1357_9BDF, TIMEOUT - 1);
    applyStimulus(2'b01, 2'b00, 32'h48, 32'h0, 32'h2468_ACE0, TIMEOUT);
    applyStimulus(2'b01, 2'b00, 32'h6, 32'h0, 32'hA5A5_5A5A, 1);
    applyStimulus(2'b11, 2'b00, 32'h31, 32'h0, 32'h7F80_8001, 0);
    applyStimulus(2'b01, 2'b10, 32'h53, 32'h0000_00C3, 32'h0, 2);

    // Reset lands in the third REQ cycle; the ack that follows must be ignored
    issue      = gcyc;
    curIssue   = issue;
    curDone    = issue + 4;
    curReqFrom = issue + 1;
    curReqTo   = issue + 3;
    curWe      = 1'b0;
    curBe      = 4'hF;
    curWd      = 32'h0;
    curAddr    = 30'h10;
    mem_read   = 2'b01;
    addr       = 32'h40;
    repeat (3) begin @(posedge clk); #1; end
    reset     = 1'b1;
    mem_read  = 2'b00;
    @(posedge clk); #1;
    reset     = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'h8765_4321;
    @(posedge clk); #1;
    bus_ack   = 1'b0;
    @(negedge clk);
    checkOutput("after_reset_rdata", rdata, 32'h0);
    checkOutput("after_reset_done", 32'(done), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      logic [1:0] rd, wr;
      int         kind, d;
      kind = $urandom_range(0, 2);
      rd   = (kind != 1) ? 2'($urandom_range(1, 3)) : 2'b00;
      wr   = (kind != 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      d    = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
      applyStimulus(rd, wr, $urandom, $urandom, $urandom, d);
    end

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
